// File: rtl/instruction_fetch_unit_pkg.sv
// Shared opcodes, widths and state/select encodings for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam int INSTR_WIDTH  = 8;
    localparam int OFFSET_WIDTH = 4;

    localparam logic [3:0] OP_HALT = 4'b0001;
    localparam logic [3:0] OP_BR0  = 4'b1010;
    localparam logic [3:0] OP_BR1  = 4'b1011;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_LATCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2
    } pc_sel_t;

    function automatic logic is_halt(input logic [INSTR_WIDTH-1:0] instr);
        return instr[INSTR_WIDTH-1:INSTR_WIDTH-4] == OP_HALT;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_next_logic.sv
// Next-PC selection: hold, increment, or add the sign-extended branch offset (modulo 2^PC_WIDTH).
module pc_next_logic
    import instruction_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = 8
) (
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic [1:0]              sel,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    output logic [PC_WIDTH-1:0]     next_pc
);

    logic signed [OFFSET_WIDTH-1:0] offset_s;
    logic signed [PC_WIDTH-1:0]     offset_ext;

    assign offset_s   = branch_offset;
    assign offset_ext = PC_WIDTH'(offset_s);

    // Unsigned addition of the sign-extended offset wraps naturally at the address-space edge.
    always_comb begin
        next_pc = pc;
        case (sel)
            PC_INC:    next_pc = pc + PC_WIDTH'(1);
            PC_BRANCH: next_pc = pc + $unsigned(offset_ext);
            default:   next_pc = pc;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: FETCH/LATCH/ISSUE/HALTED sequencer that issues one byte per instruction.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                  PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [PC_WIDTH-1:0]     mem_addr,
    output logic                    mem_rd_en,
    input  logic [INSTR_WIDTH-1:0]  mem_rdata,
    output logic [INSTR_WIDTH-1:0]  Instruction,
    output logic                    instr_valid,
    input  logic                    stall,
    input  logic                    branch_taken,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    input  logic                    resume,
    output logic [PC_WIDTH-1:0]     pc,
    output logic                    halted
);

    fetch_state_t        state;
    logic                primed;
    logic [1:0]          pc_sel;
    logic [PC_WIDTH-1:0] pc_next;

    assign mem_addr = pc;

    always_comb begin
        pc_sel = PC_HOLD;
        if (state == ST_ISSUE && !stall) begin
            if (is_halt(Instruction))
                pc_sel = PC_INC;
            else if (branch_taken)
                pc_sel = PC_BRANCH;
            else
                pc_sel = PC_INC;
        end
    end

    pc_next_logic #(
        .PC_WIDTH(PC_WIDTH)
    ) u_pc_next (
        .pc            (pc),
        .sel           (pc_sel),
        .branch_offset (branch_offset),
        .next_pc       (pc_next)
    );

    // Outputs are registered; primed spends the first post-reset edge raising the read strobe
    // so the first full cycle after reset release is a real FETCH cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_FETCH;
            primed      <= 1'b0;
            pc          <= RESET_PC;
            Instruction <= '0;
            instr_valid <= 1'b0;
            mem_rd_en   <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!primed) begin
                        primed    <= 1'b1;
                        mem_rd_en <= 1'b1;
                    end else begin
                        mem_rd_en <= 1'b0;
                        state     <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    Instruction <= mem_rdata;
                    instr_valid <= 1'b1;
                    state       <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        instr_valid <= 1'b0;
                        pc          <= pc_next;
                        if (is_halt(Instruction)) begin
                            halted <= 1'b1;
                            state  <= ST_HALTED;
                        end else begin
                            mem_rd_en <= 1'b1;
                            state     <= ST_FETCH;
                        end
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        halted    <= 1'b0;
                        mem_rd_en <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed steps plus randomized programs against a PC-level model.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (RESET_PC = 0)
    logic       reset;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] mem_rdata;
    logic [7:0] Instruction;
    logic       instr_valid;
    logic       stall;
    logic       branch_taken;
    logic [3:0] branch_offset;
    logic       resume;
    logic [7:0] pc;
    logic       halted;

    // Wrap DUT (RESET_PC = FE)
    logic       w_reset;
    logic [7:0] w_mem_addr;
    logic       w_mem_rd_en;
    logic [7:0] w_mem_rdata;
    logic [7:0] w_instr;
    logic       w_instr_valid;
    logic       w_stall;
    logic       w_branch_taken;
    logic [3:0] w_branch_offset;
    logic       w_resume;
    logic [7:0] w_pc;
    logic       w_halted;

    logic [7:0] mem  [256];
    logic [7:0] wmem [256];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    instruction_fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) u_dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .Instruction(Instruction), .instr_valid(instr_valid),
        .stall(stall), .branch_taken(branch_taken), .branch_offset(branch_offset),
        .resume(resume), .pc(pc), .halted(halted)
    );

    instruction_fetch_unit #(.PC_WIDTH(8), .RESET_PC(8'hFE)) u_wrap (
        .clk(clk), .reset(w_reset), .mem_addr(w_mem_addr), .mem_rd_en(w_mem_rd_en),
        .mem_rdata(w_mem_rdata), .Instruction(w_instr), .instr_valid(w_instr_valid),
        .stall(w_stall), .branch_taken(w_branch_taken), .branch_offset(w_branch_offset),
        .resume(w_resume), .pc(w_pc), .halted(w_halted)
    );

    // Synchronous instruction memories: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd_en)   mem_rdata   <= mem[mem_addr];
        if (w_mem_rd_en) w_mem_rdata <= wmem[w_mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!instr_valid && n < budget);
        chk("wait_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    function automatic int sext4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] wexp [3];
        int         rd_cnt;
        int         n;
        int         pc_m;
        int         nstall;
        logic       bt;
        logic [3:0] off;
        logic       exp_halt;

        wexp = '{8'hFE, 8'hFF, 8'h00};
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = 4'd0; resume = 1'b0;
        w_reset = 1'b1; w_stall = 1'b0; w_branch_taken = 1'b0; w_branch_offset = 4'd0; w_resume = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'h00;
            wmem[i] = 8'h30;
        end
        mem[0] = 8'h80; mem[1] = 8'h84; mem[2] = 8'h88; mem[3] = 8'h10;
        mem[4] = 8'hA3; mem[5] = 8'h5C;
        wmem[8'hFE] = 8'h20; wmem[8'hFF] = 8'h21; wmem[8'h00] = 8'hA0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, instr_valid}, 0);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_instr", {24'd0, Instruction}, 0);
        chk("rst_pc", {24'd0, pc}, 0);
        chk("rst_addr", {24'd0, mem_addr}, 0);
        reset = 1'b0;
        cyc = 0;

        // Straight-line issue timing
        tick();
        chk("fetch0_rd_en", {31'd0, mem_rd_en}, 1);
        chk("fetch0_addr", {24'd0, mem_addr}, 0);
        chk("fetch0_valid", {31'd0, instr_valid}, 0);
        wait_valid(5);
        chk("issue0_cycle", cyc, 3);
        chk("issue0_instr", {24'd0, Instruction}, 32'h80);
        chk("issue0_pc", {24'd0, pc}, 0);
        tick();
        chk("pulse_width", {31'd0, instr_valid}, 0);
        chk("fetch1_rd_en", {31'd0, mem_rd_en}, 1);
        chk("fetch1_addr", {24'd0, mem_addr}, 1);
        wait_valid(5);
        chk("issue1_cycle", cyc, 6);
        chk("issue1_instr", {24'd0, Instruction}, 32'h84);
        chk("issue1_pc", {24'd0, pc}, 1);

        // Stall holds the issued instruction
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_valid", {31'd0, instr_valid}, 1);
            chk("stall_instr", {24'd0, Instruction}, 32'h84);
            chk("stall_pc", {24'd0, pc}, 1);
            chk("stall_rd_en", {31'd0, mem_rd_en}, 0);
        end
        stall = 1'b0;
        tick();
        chk("post_stall_rd_en", {31'd0, mem_rd_en}, 1);
        chk("post_stall_addr", {24'd0, mem_addr}, 2);
        wait_valid(5);
        chk("issue2_instr", {24'd0, Instruction}, 32'h88);
        chk("issue2_pc", {24'd0, pc}, 2);

        // HALT stops fetching until resume
        wait_valid(5);
        chk("halt_instr", {24'd0, Instruction}, 32'h10);
        tick();
        chk("halted_flag", {31'd0, halted}, 1);
        chk("halted_valid", {31'd0, instr_valid}, 0);
        chk("halted_instr", {24'd0, Instruction}, 32'h10);
        chk("halted_pc", {24'd0, pc}, 4);
        rd_cnt = 0;
        repeat (20) begin
            tick();
            if (mem_rd_en) rd_cnt++;
        end
        chk("halt_no_fetch", rd_cnt, 0);
        chk("halt_persist", {31'd0, halted}, 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_halted", {31'd0, halted}, 0);
        chk("resume_rd_en", {31'd0, mem_rd_en}, 1);
        chk("resume_addr", {24'd0, mem_addr}, 4);

        // Taken branch, offset -2 from address 4
        wait_valid(5);
        chk("br_instr", {24'd0, Instruction}, 32'hA3);
        branch_taken = 1'b1; branch_offset = 4'b1110;
        tick();
        branch_taken = 1'b0;
        chk("br_taken_rd_en", {31'd0, mem_rd_en}, 1);
        chk("br_taken_addr", {24'd0, mem_addr}, 2);
        wait_valid(5);
        chk("br_target_instr", {24'd0, Instruction}, 32'h88);

        // Branch on HALT: HALT wins
        wait_valid(5);
        chk("halt2_instr", {24'd0, Instruction}, 32'h10);
        branch_taken = 1'b1; branch_offset = 4'b0101;
        tick();
        branch_taken = 1'b0;
        chk("halt_wins_flag", {31'd0, halted}, 1);
        chk("halt_wins_pc", {24'd0, pc}, 4);
        resume = 1'b1;
        tick();
        resume = 1'b0;

        // Not-taken branch falls through
        wait_valid(5);
        chk("br2_instr", {24'd0, Instruction}, 32'hA3);
        tick();
        chk("br_not_taken_addr", {24'd0, mem_addr}, 5);

        // Asynchronous reset in the middle of LATCH
        tick();
        #2 reset = 1'b1;
        #1;
        chk("async_valid", {31'd0, instr_valid}, 0);
        chk("async_rd_en", {31'd0, mem_rd_en}, 0);
        chk("async_instr", {24'd0, Instruction}, 0);
        chk("async_pc", {24'd0, pc}, 0);
        chk("async_addr", {24'd0, mem_addr}, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        tick();
        chk("restart_addr", {24'd0, mem_addr}, 0);
        chk("restart_rd_en", {31'd0, mem_rd_en}, 1);
        wait_valid(5);
        chk("restart_cycle", cyc, 3);
        chk("restart_instr", {24'd0, Instruction}, 32'h80);

        // PC wrap with RESET_PC = FE
        w_reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!w_mem_rd_en && n < 6);
            chk("wrap_rd_en", {31'd0, w_mem_rd_en}, 1);
            chk("wrap_addr", {24'd0, w_mem_addr}, {24'd0, wexp[k]});
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!w_instr_valid && n < 6);
        chk("wrap_valid", {31'd0, w_instr_valid}, 1);
        chk("wrap_instr", {24'd0, w_instr}, 32'hA0);
        chk("wrap_pc", {24'd0, w_pc}, 0);
        w_branch_taken = 1'b1; w_branch_offset = 4'b1111;
        tick();
        w_branch_taken = 1'b0;
        chk("wrap_br_rd_en", {31'd0, w_mem_rd_en}, 1);
        chk("wrap_br_addr", {24'd0, w_mem_addr}, 32'hFF);

        // Randomized programs, stalls and branches against a PC-level model
        reset = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        @(negedge clk);
        reset = 1'b0;
        pc_m = 0;
        for (int it = 0; it < 120; it++) begin
            wait_valid(6);
            chk("rnd_instr", {24'd0, Instruction}, {24'd0, mem[pc_m]});
            chk("rnd_pc", {24'd0, pc}, pc_m);
            nstall = $urandom_range(0, 2);
            for (int s = 0; s < nstall; s++) begin
                stall = 1'b1;
                branch_taken = 1'($urandom);
                branch_offset = 4'($urandom);
                tick();
                chk("rnd_stall_valid", {31'd0, instr_valid}, 1);
                chk("rnd_stall_pc", {24'd0, pc}, pc_m);
            end
            stall = 1'b0;
            bt = 1'($urandom);
            off = 4'($urandom);
            branch_taken = bt;
            branch_offset = off;
            exp_halt = (mem[pc_m] >> 4) == 8'h01;
            tick();
            branch_taken = 1'b0;
            if (exp_halt || !bt) pc_m = (pc_m + 1) % 256;
            else pc_m = (pc_m + sext4(off) + 256) % 256;
            if (exp_halt) begin
                chk("rnd_halted", {31'd0, halted}, 1);
                repeat ($urandom_range(0, 3)) tick();
                resume = 1'b1;
                tick();
                resume = 1'b0;
            end
            chk("rnd_fetch_rd_en", {31'd0, mem_rd_en}, 1);
            chk("rnd_fetch_addr", {24'd0, mem_addr}, pc_m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Producer side of the 8-bit instruction interface. Fetches instruction bytes from a synchronous instruction memory and presents them one at a time on Instruction/instr_valid to the control unit.
- Maintains the program counter (PC) and applies taken branches using the decoder's 4-bit signed BranchOffset.
- Stops issuing on HALT (opcode 0001).
- Sits between instruction memory and the control unit/datapath.

Parameters:
- PC_WIDTH, 8, program counter and memory address width; address space is 2^PC_WIDTH bytes.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_addr  output  PC_WIDTH  instruction memory address.
- mem_rd_en  output  1  memory read strobe.
- mem_rdata  input  8  memory read data; valid one cycle after a cycle with mem_rd_en=1.
- Instruction  output  8  issued instruction byte (registered).
- instr_valid  output  1  Instruction is valid this cycle.
- stall  input  1  datapath not ready; hold the current instruction.
- branch_taken  input  1  branch condition true for the issued instruction.
- branch_offset  input  4  signed offset (BranchOffset from the control unit).
- resume  input  1  leave HALTED.
- pc  output  PC_WIDTH  address of the instruction currently issued or being fetched.
- halted  output  1  fetch stopped on HALT.

Behaviour:
- Reset values (asynchronous, while reset=1):
  - PC=RESET_PC, state=FETCH.
  - Instruction=8'h00; instr_valid, mem_rd_en and halted all 0.
  - mem_addr=RESET_PC.
- FSM states: FETCH, LATCH, ISSUE, HALTED.
- FETCH: mem_rd_en=1, mem_addr=PC; always transitions to LATCH.
- LATCH: mem_rd_en=0; mem_rdata is valid. Instruction<=mem_rdata at the clock edge ending LATCH; transitions to ISSUE.
- ISSUE: instr_valid=1 and Instruction held stable.
  - stall=1: remain in ISSUE; PC and Instruction unchanged; branch_taken is ignored until the cycle stall=0.
  - stall=0 and Instruction[7:4]==4'b0001 (HALT): PC<=PC+1, go to HALTED.
  - stall=0 and branch_taken=1: PC<=PC+sign_extend(branch_offset), go to FETCH.
  - stall=0 otherwise: PC<=PC+1, go to FETCH.
- HALTED: halted=1, instr_valid=0, mem_rd_en=0, Instruction retains the HALT byte.
  - resume=1: go to FETCH; halted drops in that same FETCH cycle.
  - resume is ignored in every other state.
- Latency and throughput:
  - First FETCH is the first cycle after reset deasserts.
  - instr_valid first asserts 2 cycles later.
  - Unstalled throughput is 1 instruction per 3 cycles.
  - instr_valid is high for exactly 1 cycle per instruction when unstalled.
- Arithmetic: PC arithmetic is modulo 2^PC_WIDTH, so PC_WIDTH'hFF+1 wraps to 0 and 0+(-1) wraps to FF. branch_offset is sign-extended from bit 3 to PC_WIDTH; the target is relative to the branch instruction's own address.
- branch_taken with offset 0: PC is unchanged and the same instruction is refetched; this is legal, not an error.
- branch_taken asserted on a HALT instruction: HALT wins.
- Illegal opcodes: issued unchanged; the control unit flags them, and fetch applies no special handling.
- Reset mid-operation: any state returns to FETCH at RESET_PC immediately. Outputs take their reset values asynchronously; no partial instruction is issued.

Decomposition:
- Shared package:
  - opcode constants: OP_HALT=4'b0001, OP_BR0=4'b1010, OP_BR1=4'b1011.
  - FSM state typedef/localparams.
  - INSTR_WIDTH=8.
  - OFFSET_WIDTH=4.
- One natural sub-module, pc_next_logic: combinational next-PC selection (hold / +1 / +sext offset) with wrap.
- FSM and registers stay in instruction_fetch_unit.

Test Plan:
- Reset release, memory = {0x80,0x84,0x88}, stall=0 -> instr_valid pulses on cycles 3, 6, 9 with Instruction 0x80, 0x84, 0x88; pc=0, 1, 2.
- Branch: mem[4]=0xA3 with branch_offset=4'b1110 and branch_taken=1 in ISSUE -> next fetch mem_addr=2. Repeat with branch_taken=0 -> next mem_addr=5.
- Stall: hold stall=1 for 4 cycles while 0x84 is issued -> instr_valid stays 1, Instruction=0x84, pc unchanged, no mem_rd_en. After stall falls, next FETCH at pc+1.
- HALT: mem[3]=0x10 -> after issue, halted=1, instr_valid=0, no further mem_rd_en for 20 cycles. Pulse resume -> FETCH at address 4.
- Wrap: RESET_PC=8'hFE, straight-line code -> fetch addresses FE, FF, 00. Branch at 00 with offset 4'b1111 -> next fetch FF.
- Asynchronous reset asserted mid-LATCH (between edges) -> outputs clear immediately. After release, fetch restarts at RESET_PC and the in-flight byte is never issued.
